maze_walker: RTL and testbench

- Parametrised wall-following maze explorer; successor to the fixed 64x64 right-hand solver.
- Drives the maze memory read/write port (row, col, maze_oe, maze_we) from a registered FSM.
- Adds start/busy control, selectable hand rule, a move counter, a step limit, and trapped/timeout failure reporting.
- Sits between the control sequencer (start, starting position) and the maze memory.

---
 rtl/maze_walker.sv | 166 ++++++++++++++++
 tb/tb_maze_walker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_walker.sv
// maze_walker: wall-following maze explorer with selectable hand rule, step limit and
// trapped/timeout reporting. A single registered FSM marks each cell, then probes neighbours.
module maze_walker #(
    parameter int maze_width = 6,
    parameter int STEP_W     = 16,
    parameter int MAX_STEPS  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hand,
    input  logic [maze_width-1:0] starting_row,
    input  logic [maze_width-1:0] starting_col,
    input  logic                  maze_in,
    output logic [maze_width-1:0] row,
    output logic [maze_width-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [STEP_W-1:0]     steps
);
    typedef enum logic [1:0] {IDLE, MARK, PROBE, EVAL} state_t;

    localparam logic [maze_width-1:0] BORDER_MAX = '1;
    localparam logic [maze_width-1:0] COORD_ONE  = maze_width'(1);
    localparam logic [STEP_W-1:0]     STEP_LIMIT = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0]     STEP_ONE   = STEP_W'(1);

    state_t                state, state_n;
    logic [maze_width-1:0] pos_row, pos_row_n, pos_col, pos_col_n, row_n, col_n;
    logic [1:0]            heading, heading_n, try_q, try_n, next_try, cand_dir;
    logic                  hand_q, hand_n, done_n, fail_n, on_border;
    logic [STEP_W-1:0]     steps_n;
    logic [2*maze_width-1:0] next_cell;

    // Left-hand order is the right-hand order mirrored, i.e. each offset negated mod 4.
    function automatic logic [1:0] probe_dir(input logic [1:0] h, input logic left,
                                             input logic [1:0] t);
        logic [1:0] off;
        case (t)
            2'd0:    off = 2'd1;
            2'd1:    off = 2'd0;
            2'd2:    off = 2'd3;
            default: off = 2'd2;
        endcase
        return left ? h - off : h + off;
    endfunction

    function automatic logic [2*maze_width-1:0] neighbour(input logic [maze_width-1:0] r,
                                                          input logic [maze_width-1:0] c,
                                                          input logic [1:0] d);
        logic [maze_width-1:0] nr, nc;
        nr = r;
        nc = c;
        case (d)
            2'd0:    nr = r - COORD_ONE;
            2'd1:    nc = c + COORD_ONE;
            2'd2:    nr = r + COORD_ONE;
            default: nc = c - COORD_ONE;
        endcase
        return {nr, nc};
    endfunction

    assign cand_dir  = probe_dir(heading, hand_q, try_q);
    assign next_try  = (state == MARK) ? 2'd0 : try_q + 2'd1;
    assign next_cell = neighbour(pos_row, pos_col, probe_dir(heading, hand_q, next_try));
    assign on_border = (pos_row == '0) || (pos_row == BORDER_MAX) ||
                       (pos_col == '0) || (pos_col == BORDER_MAX);

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_n   = state;
        pos_row_n = pos_row;
        pos_col_n = pos_col;
        row_n     = row;
        col_n     = col;
        heading_n = heading;
        try_n     = try_q;
        hand_n    = hand_q;
        done_n    = done;
        fail_n    = fail;
        steps_n   = steps;
        case (state)
            IDLE: if (start) begin
                pos_row_n = starting_row;
                pos_col_n = starting_col;
                row_n     = starting_row;
                col_n     = starting_col;
                hand_n    = hand;
                heading_n = 2'd0;
                steps_n   = '0;
                done_n    = 1'b0;
                fail_n    = 1'b0;
                state_n   = MARK;
            end
            MARK: begin
                // A border start only counts as an exit once the walker has moved.
                if (steps != '0 && on_border) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (steps == STEP_LIMIT) begin
                    fail_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    try_n          = next_try;
                    {row_n, col_n} = next_cell;
                    state_n        = PROBE;
                end
            end
            PROBE: state_n = EVAL;
            EVAL: begin
                // The probe address still on row/col becomes the new position and MARK address.
                if (!maze_in) begin
                    pos_row_n = row;
                    pos_col_n = col;
                    heading_n = cand_dir;
                    steps_n   = steps + STEP_ONE;
                    state_n   = MARK;
                end else if (try_q == 2'd3) begin
                    fail_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    try_n          = next_try;
                    {row_n, col_n} = next_cell;
                    state_n        = PROBE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos_row <= '0;
            pos_col <= '0;
            row     <= '0;
            col     <= '0;
            heading <= 2'd0;
            try_q   <= 2'd0;
            hand_q  <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            steps   <= '0;
        end else begin
            state   <= state_n;
            pos_row <= pos_row_n;
            pos_col <= pos_col_n;
            row     <= row_n;
            col     <= col_n;
            heading <= heading_n;
            try_q   <= try_n;
            hand_q  <= hand_n;
            done    <= done_n;
            fail    <= fail_n;
            steps   <= steps_n;
        end
    end

    assign maze_we = (state == MARK);
    assign maze_oe = (state == PROBE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_maze_walker.sv
// tb_maze_walker: drives directed and random mazes into maze_walker and compares the access
// trace, timing and final status against a walk computed directly from the hand rules.
module tb_maze_walker;
    localparam int MW     = 3;
    localparam int N      = 1 << MW;
    localparam int SW     = 8;
    localparam int MS     = 16;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst_n, start, hand, maze_in;
    logic [MW-1:0] starting_row, starting_col, row, col;
    logic          maze_oe, maze_we, busy, done, fail;
    logic [SW-1:0] steps;

    int n_checks = 0;
    int n_fail   = 0;

    bit maze_mem [N][N];

    int exp_kind[$], exp_r[$], exp_c[$], exp_cyc[$];
    int exp_end, exp_steps;
    bit exp_done, exp_fail;
    int obs_kind[$], obs_r[$], obs_c[$], obs_cyc[$];
    int obs_end;

    maze_walker #(.maze_width(MW), .STEP_W(SW), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hand(hand),
        .starting_row(starting_row), .starting_col(starting_col), .maze_in(maze_in),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .busy(busy), .done(done), .fail(fail), .steps(steps)
    );

    always #5 clk = ~clk;

    // Memory returns the cell one cycle after the read strobe.
    always @(posedge clk) if (maze_oe) maze_in <= maze_mem[row][col];

    task automatic fill_walls();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) maze_mem[r][c] = 1'b1;
    endtask

    task automatic open_field();
        fill_walls();
        for (int r = 1; r < N - 1; r++)
            for (int c = 1; c < N - 1; c++) maze_mem[r][c] = 1'b0;
    endtask

    // Walk the maze by the rule: MARK at cyc, try k probed at cyc+1+2k, next MARK at cyc+3+2k.
    task automatic model_walk(input int sr, input int sc, input bit hnd);
        int dr[4], dc[4], rh[4], lh[4];
        int r, c, h, st, cyc, d, nr, nc;
        bit moved;
        dr = '{-1, 0, 1, 0};
        dc = '{0, 1, 0, -1};
        rh = '{1, 0, 3, 2};
        lh = '{3, 0, 1, 2};
        r = sr; c = sc; h = 0; st = 0; cyc = 0;
        exp_kind.delete(); exp_r.delete(); exp_c.delete(); exp_cyc.delete();
        exp_done = 0; exp_fail = 0;
        forever begin
            exp_kind.push_back(0); exp_r.push_back(r); exp_c.push_back(c); exp_cyc.push_back(cyc);
            if (st != 0 && (r == 0 || r == N - 1 || c == 0 || c == N - 1)) begin
                exp_done = 1; exp_end = cyc + 1; break;
            end
            if (st == MS) begin
                exp_fail = 1; exp_end = cyc + 1; break;
            end
            moved = 0;
            for (int k = 0; k < 4; k++) begin
                d  = (h + (hnd ? lh[k] : rh[k])) % 4;
                nr = (r + dr[d] + N) % N;
                nc = (c + dc[d] + N) % N;
                exp_kind.push_back(1); exp_r.push_back(nr); exp_c.push_back(nc);
                exp_cyc.push_back(cyc + 1 + 2 * k);
                if (!maze_mem[nr][nc]) begin
                    r = nr; c = nc; h = d; st++;
                    cyc = cyc + 3 + 2 * k;
                    moved = 1;
                    break;
                end
            end
            if (!moved) begin
                exp_fail = 1; exp_end = cyc + 9; break;
            end
        end
        exp_steps = st;
    endtask

    function automatic int first_read_idx();
        for (int i = 0; i < obs_kind.size(); i++) if (obs_kind[i] == 1) return i;
        return -1;
    endfunction

    // Generic walk scenario: start, record every strobe, compare trace and status with the model.
    task automatic test_walk(input string name, input int sr, input int sc, input bit hnd,
                             input bit do_poke);
        int  busy_err = 0, both_err = 0, poke_cyc = -1, bad = -1;
        bit  finished = 0;
        model_walk(sr, sc, hnd);
        if (do_poke) poke_cyc = exp_end / 2;
        obs_kind.delete(); obs_r.delete(); obs_c.delete(); obs_cyc.delete();
        obs_end = -1;
        @(negedge clk);
        start = 1'b1; starting_row = MW'(sr); starting_col = MW'(sc); hand = hnd;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (maze_oe && maze_we) both_err++;
            if (busy !== (k < exp_end)) busy_err++;
            if (maze_we) begin
                obs_kind.push_back(0); obs_r.push_back(int'(row)); obs_c.push_back(int'(col));
                obs_cyc.push_back(k);
            end
            if (maze_oe) begin
                obs_kind.push_back(1); obs_r.push_back(int'(row)); obs_c.push_back(int'(col));
                obs_cyc.push_back(k);
            end
            if (k == poke_cyc) begin
                start = 1'b1; hand = 1'($urandom_range(0, 1));
                starting_row = MW'($urandom_range(0, N - 1));
                starting_col = MW'($urandom_range(0, N - 1));
            end else begin
                start = 1'b0;
            end
            if (done || fail) begin
                obs_end = k; finished = 1; break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: no done/fail within %0d cycles, expected at cycle %0d",
                     name, BUDGET, exp_end);
        end
        n_checks++;
        if (obs_end !== exp_end) begin
            n_fail++; $display("FAIL %s end_cycle: got %0d expected %0d", name, obs_end, exp_end);
        end
        n_checks++;
        if ({done, fail} !== {exp_done, exp_fail}) begin
            n_fail++;
            $display("FAIL %s status: got done=%0b fail=%0b expected done=%0b fail=%0b",
                     name, done, fail, exp_done, exp_fail);
        end
        n_checks++;
        if (int'(steps) !== exp_steps) begin
            n_fail++; $display("FAIL %s steps: got %0d expected %0d", name, steps, exp_steps);
        end
        n_checks++;
        if (obs_kind.size() != exp_kind.size()) bad = 0;
        for (int i = 0; i < exp_kind.size() && bad < 0; i++)
            if (obs_kind[i] != exp_kind[i] || obs_r[i] != exp_r[i] ||
                obs_c[i] != exp_c[i] || obs_cyc[i] != exp_cyc[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            if (obs_kind.size() != exp_kind.size())
                $display("FAIL %s trace: got %0d accesses expected %0d",
                         name, obs_kind.size(), exp_kind.size());
            else
                $display("FAIL %s trace: access %0d got kind %0d (%0d,%0d)@%0d expected kind %0d (%0d,%0d)@%0d",
                         name, bad, obs_kind[bad], obs_r[bad], obs_c[bad], obs_cyc[bad],
                         exp_kind[bad], exp_r[bad], exp_c[bad], exp_cyc[bad]);
        end
        n_checks++;
        if (busy_err != 0 || both_err != 0) begin
            n_fail++;
            $display("FAIL %s strobes: got %0d busy errors and %0d oe/we overlaps expected 0 and 0",
                     name, busy_err, both_err);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({row, col, maze_oe, maze_we, busy, done, fail, steps} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got outputs %h expected 0",
                     {row, col, maze_oe, maze_we, busy, done, fail, steps});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({row, col, maze_oe, maze_we, busy, done, fail, steps} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got outputs %h expected 0",
                     {row, col, maze_oe, maze_we, busy, done, fail, steps});
        end
    endtask

    task automatic corridor_maze();
        fill_walls();
        for (int r = 0; r < 4; r++) maze_mem[r][3] = 1'b0;
    endtask

    task automatic test_corridor();
        int wr[$];
        int idx = 0;
        bit ok = 1;
        corridor_maze();
        test_walk("corridor", 3, 3, 1'b0, 1'b0);
        n_checks++;
        if (obs_end !== 16 || steps !== SW'(3) || done !== 1'b1 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL corridor_fixed: got end=%0d steps=%0d done=%0b fail=%0b expected 16 3 1 0",
                     obs_end, steps, done, fail);
        end
        for (int i = 0; i < obs_kind.size(); i++)
            if (obs_kind[i] == 0) wr.push_back(obs_r[i] * 16 + obs_c[i]);
        if (wr.size() != 4) ok = 0;
        else for (int i = 0; i < 4; i++) if (wr[i] != (3 - i) * 16 + 3) ok = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL corridor_writes: got %0d marks expected (3,3),(2,3),(1,3),(0,3)", wr.size());
        end
        idx = first_read_idx();
    endtask

    task automatic test_enclosed();
        int want_r[4], want_c[4];
        int idx;
        bit ok = 1;
        want_r = '{4, 3, 4, 5};
        want_c = '{5, 4, 3, 4};
        fill_walls();
        maze_mem[4][4] = 1'b0;
        test_walk("enclosed", 4, 4, 1'b0, 1'b0);
        idx = first_read_idx();
        if (idx < 0 || idx + 4 > obs_kind.size()) ok = 0;
        else for (int i = 0; i < 4; i++)
            if (obs_r[idx + i] != want_r[i] || obs_c[idx + i] != want_c[i]) ok = 0;
        n_checks++;
        if (!ok || obs_end !== 9 || steps !== '0 || fail !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL enclosed_fixed: got order_ok=%0b end=%0d steps=%0d fail=%0b done=%0b expected 1 9 0 1 0",
                     ok, obs_end, steps, fail, done);
        end
    endtask

    task automatic test_open_field();
        open_field();
        test_walk("open_field", 3, 3, 1'b0, 1'b0);
        n_checks++;
        if (fail !== 1'b1 || done !== 1'b0 || steps !== SW'(MS)) begin
            n_fail++;
            $display("FAIL open_field_limit: got fail=%0b done=%0b steps=%0d expected 1 0 %0d",
                     fail, done, steps, MS);
        end
    endtask

    task automatic test_hand_select();
        int idx;
        open_field();
        test_walk("hand_right", 3, 3, 1'b0, 1'b0);
        idx = first_read_idx();
        n_checks++;
        if (idx < 0 || obs_r[idx] != 3 || obs_c[idx] != 4) begin
            n_fail++; $display("FAIL hand_right_first: got index %0d expected probe (3,4)", idx);
        end
        test_walk("hand_left", 3, 3, 1'b1, 1'b0);
        idx = first_read_idx();
        n_checks++;
        if (idx < 0 || obs_r[idx] != 3 || obs_c[idx] != 2) begin
            n_fail++; $display("FAIL hand_left_first: got index %0d expected probe (3,2)", idx);
        end
    endtask

    task automatic test_border_start();
        fill_walls();
        maze_mem[0][3] = 1'b0;
        maze_mem[1][3] = 1'b0;
        test_walk("border_start", 0, 3, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || steps !== SW'(2) || obs_end !== 19) begin
            n_fail++;
            $display("FAIL border_start_fixed: got done=%0b steps=%0d end=%0d expected 1 2 19",
                     done, steps, obs_end);
        end
    endtask

    task automatic test_start_ignored();
        open_field();
        test_walk("start_ignored", 3, 3, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_probe();
        bit seen = 0;
        corridor_maze();
        @(negedge clk);
        start = 1'b1; starting_row = 3'd3; starting_col = 3'd3; hand = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (maze_oe) seen = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_mid_probe_wait: got no maze_oe within 50 cycles expected one");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({row, col, maze_oe, maze_we, busy, done, fail, steps} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_probe: got outputs %h expected 0",
                     {row, col, maze_oe, maze_we, busy, done, fail, steps});
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_walk("corridor_after_reset", 3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int sr, sc;
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) maze_mem[r][c] = ($urandom_range(0, 99) < 35);
            sr = $urandom_range(0, N - 1);
            sc = $urandom_range(0, N - 1);
            test_walk($sformatf("random%0d", it), sr, sc, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hand = 1'b0;
        starting_row = '0; starting_col = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_corridor();
        test_enclosed();
        test_open_field();
        test_hand_select();
        test_border_start();
        test_start_ignored();
        test_reset_mid_probe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
